usb_tx_packetizer: RTL and testbench

//  Parametrised next-generation USB full-speed transmitter. Serialises one complete packet per

---
 rtl/usb_tx_packetizer.sv | 117 +++++++++++
 tb/tb_usb_tx_packetizer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: USB full-speed packet serialiser with bit stuffing, NRZI and CRC16.
// Emits SYNC, PID, optional payload plus CRC, then EOP, each bit CLKS_PER_BIT clocks wide.
module usb_tx_packetizer #(
    parameter int DATA_BYTES   = 8,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tx_start,
    input  logic [3:0]                        tx_pid,
    input  logic [$clog2(DATA_BYTES+1)-1:0]   tx_len,
    input  logic [8*DATA_BYTES-1:0]           tx_data,
    output logic                              tx_busy,
    output logic                              tx_done,
    output logic                              d_plus,
    output logic                              d_minus
);
    localparam int LW = $clog2(DATA_BYTES+1);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(8*DATA_BYTES+17);
    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP} state_t;
    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [BW-1:0]           nb_q;
    logic [15:0]             hdr_q;
    logic [15:0]             crc_q;
    logic [8*DATA_BYTES-1:0] data_q;
    logic [LW-1:0]           len_q;
    logic                    dat_q;
    logic [2:0]              ones_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    dp_q;
    logic                    dm_q;
    logic                    tick;
    logic                    stuff;
    logic                    last;
    logic                    bit_d;
    logic [15:0]             crc_d;
    assign tick  = cnt_q == CW'(CLKS_PER_BIT-1);
    assign stuff = ones_q == 3'd6;
    assign last  = nb_q == BW'(1);
    assign bit_d = stuff ? 1'b0 : state_q == DATA ? data_q[0] : state_q == CRC ? ~crc_q[0] : hdr_q[0];
    assign crc_d = (crc_q >> 1) ^ ((crc_q[0] ^ data_q[0]) ? 16'hA001 : 16'h0000);
    // The accept edge preloads the bit counter so the first SYNC bit goes out on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nb_q    <= '0;
            hdr_q   <= '0;
            crc_q   <= 16'hFFFF;
            data_q  <= '0;
            len_q   <= '0;
            dat_q   <= 1'b0;
            ones_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dp_q    <= 1'b1;
            dm_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (tx_start) begin
                    state_q <= SYNC;
                    cnt_q   <= CW'(CLKS_PER_BIT-1);
                    nb_q    <= BW'(8);
                    hdr_q   <= {~tx_pid, tx_pid, 8'h80};
                    crc_q   <= 16'hFFFF;
                    data_q  <= tx_data;
                    len_q   <= tx_len > LW'(DATA_BYTES) ? LW'(DATA_BYTES) : tx_len;
                    dat_q   <= tx_pid[2:0] == 3'b011;
                end
            end else begin
                cnt_q <= tick ? '0 : cnt_q + CW'(1);
                if (tick && state_q == EOP && !stuff) begin
                    ones_q <= 3'd0;
                    nb_q   <= nb_q - BW'(1);
                    dp_q   <= nb_q < BW'(2);
                    dm_q   <= 1'b0;
                    if (nb_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end else if (tick) begin
                    busy_q <= 1'b1;
                    dp_q   <= dp_q ^ ~bit_d;
                    dm_q   <= ~(dp_q ^ ~bit_d);
                    ones_q <= bit_d ? ones_q + 3'd1 : 3'd0;
                    if (!stuff) begin
                        nb_q  <= nb_q - BW'(1);
                        hdr_q <= hdr_q >> 1;
                        if (state_q == DATA) begin
                            data_q <= data_q >> 1;
                            crc_q  <= crc_d;
                        end
                        if (state_q == CRC)
                            crc_q <= crc_q >> 1;
                        if (last) begin
                            state_q <= state_q == SYNC ? PID :
                                       state_q == PID  ? (!dat_q ? EOP : len_q == '0 ? CRC : DATA) :
                                       state_q == DATA ? CRC : EOP;
                            nb_q    <= state_q == SYNC ? BW'(8) :
                                       state_q == PID  ? (!dat_q ? BW'(3) : len_q == '0 ? BW'(16) : BW'({len_q, 3'b000})) :
                                       state_q == DATA ? BW'(16) : BW'(3);
                        end
                    end
                end
            end
        end
    end
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign d_plus  = dp_q;
    assign d_minus = dm_q;
endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb_usb_tx_packetizer: directed bench decoding the D+/D- line back into packet fields.
module tb_usb_tx_packetizer;
    localparam int DB = 9;
    localparam int CPB = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_start = 1'b0;
    logic [3:0] tx_pid = 4'd0;
    logic [3:0] tx_len = 4'd0;
    logic [8*DB-1:0] tx_data = '0;
    logic tx_busy, tx_done, d_plus, d_minus;
    int tests = 0;
    int fails = 0;
    logic [1:0] sym [0:255];
    int nsym, busy_cnt, done_cnt, ndb, nstuff, nst_rng;
    logic got, done_end, bad, eop_ok;
    logic dbits [0:1023];
    logic [7:0] pay [0:15];

    usb_tx_packetizer #(.DATA_BYTES(DB), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len),
        .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done), .d_plus(d_plus), .d_minus(d_minus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] crc16(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c ^= {8'h00, pay[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? (c >> 1) ^ 16'hA001 : c >> 1;
        end
        return c;
    endfunction

    function automatic logic [15:0] field(input int o, input int w);
        logic [15:0] v = '0;
        for (int j = 0; j < w; j++) v[j] = dbits[o+j];
        return v;
    endfunction

    task automatic send(input logic [3:0] pid, input logic [3:0] len);
        @(negedge clk);
        tx_pid = pid;
        tx_len = len;
        for (int k = 0; k < DB; k++) tx_data[8*k +: 8] = pay[k];
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic capture;
        nsym = 0; busy_cnt = 0; done_cnt = 0;
        for (int w = 0; w < 10 && !tx_busy; w++) @(negedge clk);
        got = tx_busy;
        for (int c = 0; c < 2000 && tx_busy; c++) begin
            if (c % CPB == 0 && nsym < 256) begin
                sym[nsym] = {d_plus, d_minus};
                nsym++;
            end
            busy_cnt++;
            if (tx_done) done_cnt++;
            @(negedge clk);
        end
        done_end = tx_done;
        if (tx_done) done_cnt++;
    endtask

    task automatic decode(input int plo, input int phi);
        logic [1:0] prev = 2'b10;
        int ones = 0;
        logic b;
        ndb = 0; nstuff = 0; nst_rng = 0; bad = 1'b0;
        for (int i = 0; i < nsym - 3; i++) begin
            if (sym[i] != 2'b10 && sym[i] != 2'b01) bad = 1'b1;
            b = sym[i] == prev;
            prev = sym[i];
            if (ones == 6) begin
                if (b) bad = 1'b1;
                nstuff++;
                if (ndb > plo && ndb <= phi) nst_rng++;
                ones = 0;
            end else begin
                dbits[ndb] = b;
                ndb++;
                ones = b ? ones + 1 : 0;
            end
        end
        eop_ok = nsym >= 3 && sym[nsym-3] == 2'b00 && sym[nsym-2] == 2'b00 && sym[nsym-1] == 2'b10;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++;
        if ({d_plus, d_minus, tx_busy, tx_done} !== 4'b1000) begin
            fails++; $display("FAIL reset_state got %b want 1000", {d_plus, d_minus, tx_busy, tx_done});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({d_plus, d_minus, tx_busy, tx_done} !== 4'b1000) begin
            fails++; $display("FAIL idle_state got %b want 1000", {d_plus, d_minus, tx_busy, tx_done});
        end
    endtask

    task automatic test_ack;
        logic [15:0] s;
        send(4'b0010, 4'd0);
        capture();
        decode(0, 0);
        s = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5], sym[6], sym[7]};
        tests++;
        if (!got || nsym != 19) begin
            fails++; $display("FAIL ack_bits got %0d want 19 (started %b)", nsym, got);
        end
        tests++;
        if (s !== 16'h6665) begin
            fails++; $display("FAIL ack_sync got %h want 6665 (KJKJKJKK)", s);
        end
        tests++;
        if (field(0, 8) !== 16'h0080 || field(8, 8) !== 16'h00D2) begin
            fails++; $display("FAIL ack_pid got sync %h pid %h want 80 d2", field(0, 8), field(8, 8));
        end
        tests++;
        if (nstuff != 0 || ndb != 16 || bad || !eop_ok) begin
            fails++; $display("FAIL ack_frame got stuff %0d bits %0d bad %b eop %b want 0 16 0 1", nstuff, ndb, bad, eop_ok);
        end
        tests++;
        if (busy_cnt != 19*CPB) begin
            fails++; $display("FAIL ack_busy got %0d want %0d", busy_cnt, 19*CPB);
        end
        tests++;
        if (done_cnt != 1 || !done_end) begin
            fails++; $display("FAIL ack_done got %0d pulses end %b want 1 1", done_cnt, done_end);
        end
    endtask

    task automatic test_zero_len;
        int tog = 0;
        send(4'b1011, 4'd0);
        capture();
        decode(16, 16);
        for (int i = 16; i < 32; i++) if (sym[i] != sym[i-1]) tog++;
        tests++;
        if (nsym != 35 || busy_cnt != 35*CPB) begin
            fails++; $display("FAIL zlen_len got %0d bits %0d cycles want 35 %0d", nsym, busy_cnt, 35*CPB);
        end
        tests++;
        if (field(8, 8) !== 16'h004B || field(16, 16) !== 16'h0000 || ndb != 32) begin
            fails++; $display("FAIL zlen_fields got pid %h crc %h bits %0d want 4b 0000 32", field(8, 8), field(16, 16), ndb);
        end
        tests++;
        if (tog != 16 || !eop_ok || bad || done_cnt != 1) begin
            fails++; $display("FAIL zlen_line got toggles %0d eop %b bad %b done %0d want 16 1 0 1", tog, eop_ok, bad, done_cnt);
        end
    endtask

    task automatic test_stuffing;
        pay[0] = 8'hFF; pay[1] = 8'hFF;
        send(4'b0011, 4'd2);
        capture();
        decode(16, 32);
        tests++;
        if (field(8, 8) !== 16'h00C3 || field(16, 16) !== 16'hFFFF) begin
            fails++; $display("FAIL stuff_data got pid %h data %h want c3 ffff", field(8, 8), field(16, 16));
        end
        tests++;
        if (nst_rng != 3 || bad) begin
            fails++; $display("FAIL stuff_count got %0d bad %b want 3 0", nst_rng, bad);
        end
        tests++;
        if (field(32, 16) !== ~crc16(2) || ndb != 48) begin
            fails++; $display("FAIL stuff_crc got %h bits %0d want %h 48", field(32, 16), ndb, ~crc16(2));
        end
        tests++;
        if (!eop_ok || nsym != ndb + nstuff + 3 || busy_cnt != CPB*nsym) begin
            fails++; $display("FAIL stuff_frame got eop %b sym %0d cycles %0d", eop_ok, nsym, busy_cnt);
        end
    endtask

    task automatic test_crc_check;
        logic ok = 1'b1;
        for (int i = 0; i < DB; i++) pay[i] = 8'h31 + 8'(i);
        send(4'b0011, 4'd9);
        capture();
        decode(16, 88);
        for (int i = 0; i < DB; i++) if (field(16 + 8*i, 8) !== {8'h00, pay[i]}) ok = 1'b0;
        tests++;
        if (!ok || ndb != 104) begin
            fails++; $display("FAIL crc9_payload got match %b bits %0d want 1 104", ok, ndb);
        end
        tests++;
        if (field(88, 16) !== ~crc16(9) || !eop_ok || bad) begin
            fails++; $display("FAIL crc9_field got %h want %h", field(88, 16), ~crc16(9));
        end
        send(4'b0011, 4'd15);
        capture();
        decode(16, 88);
        tests++;
        if (ndb != 104 || field(88, 16) !== ~crc16(9) || !eop_ok) begin
            fails++; $display("FAIL clamp_len got bits %0d crc %h want 104 %h", ndb, field(88, 16), ~crc16(9));
        end
    endtask

    task automatic test_reset_abort;
        int w = 0;
        send(4'b0011, 4'd9);
        while (!tx_busy && w < 10) begin @(negedge clk); w++; end
        repeat (24*CPB) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({d_plus, d_minus, tx_busy} !== 3'b100) begin
            fails++; $display("FAIL abort_async got %b want 100", {d_plus, d_minus, tx_busy});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if ({d_plus, d_minus, tx_busy, tx_done} !== 4'b1000) begin
            fails++; $display("FAIL abort_idle got %b want 1000", {d_plus, d_minus, tx_busy, tx_done});
        end
        send(4'b0010, 4'd0);
        capture();
        decode(0, 0);
        tests++;
        if (nsym != 19 || field(8, 8) !== 16'h00D2 || !eop_ok || bad) begin
            fails++; $display("FAIL abort_next got bits %0d pid %h eop %b want 19 d2 1", nsym, field(8, 8), eop_ok);
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        send(4'b0010, 4'd0);
        fork
            capture();
            begin
                repeat (40) @(negedge clk);
                tx_pid = 4'b1010; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
            end
        join
        decode(0, 0);
        tests++;
        if (nsym != 19 || field(8, 8) !== 16'h00D2) begin
            fails++; $display("FAIL busy_ignore got bits %0d pid %h want 19 d2", nsym, field(8, 8));
        end
        repeat (20) begin @(negedge clk); if (tx_busy) n++; end
        tests++;
        if (n != 0) begin
            fails++; $display("FAIL no_queue got %0d busy cycles want 0", n);
        end
        send(4'b0010, 4'd0);
        fork
            capture();
            begin
                repeat (100) @(negedge clk);
                tx_pid = 4'b1010; tx_start = 1'b1;
            end
        join
        tests++;
        if (!done_end || tx_busy) begin
            fails++; $display("FAIL b2b_done got done %b busy %b want 1 0", done_end, tx_busy);
        end
        @(negedge clk);
        tx_start = 1'b0;
        tests++;
        if ({tx_busy, tx_done} !== 2'b00) begin
            fails++; $display("FAIL b2b_gap got %b want 00", {tx_busy, tx_done});
        end
        @(negedge clk);
        tests++;
        if ({tx_busy, d_plus, d_minus} !== 3'b101) begin
            fails++; $display("FAIL b2b_start got %b want 101", {tx_busy, d_plus, d_minus});
        end
        capture();
        decode(0, 0);
        tests++;
        if (nsym != 19 || field(8, 8) !== 16'h005A || !eop_ok || bad) begin
            fails++; $display("FAIL b2b_pkt got bits %0d pid %h eop %b want 19 5a 1", nsym, field(8, 8), eop_ok);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pay[i] = 8'h00;
        test_reset();
        test_ack();
        test_zero_len();
        test_stuffing();
        test_crc_check();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
